// File: rtl/ysyx_22050612_ifetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder,
// its range checker, the IFU and the DPI memory wrapper.
package ysyx_22050612_ifetch_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [31:0] ERR_INST  = 32'h0;
   localparam logic [63:0] PMEM_BASE = 64'h0000_0000_8000_0000;
   localparam logic [63:0] PMEM_SIZE = 64'h0000_0000_0800_0000;

   function automatic logic [31:0] sel_half(
      input logic [63:0] beat,
      input logic        hi
   );
      return hi ? beat[63:32] : beat[31:0];
   endfunction

endpackage

// File: rtl/ysyx_22050612_fetch_range_chk.sv
// Combinational fetch-address check: misaligned word or outside
// [BASE, BASE+SIZE); the limit is formed in 65 bits so it cannot wrap.
module ysyx_22050612_fetch_range_chk
   import ysyx_22050612_ifetch_responder_pkg::*;
#(
   parameter logic [63:0] BASE = PMEM_BASE,
   parameter logic [63:0] SIZE = PMEM_SIZE
) (
   input  logic [63:0] addr,
   output logic        err
);

   logic [64:0] limit;
   logic        misal;
   logic        below;
   logic        above;

   always_comb begin
      limit = {1'b0, BASE} + {1'b0, SIZE};
      misal = |addr[1:0];
      below = addr < BASE;
      above = {1'b0, addr} >= limit;
      err   = misal | below | above;
   end

endmodule

// File: rtl/ysyx_22050612_ifetch_responder.sv
// Single-outstanding instruction fetch responder with programmable
// latency, 64-bit memory beat to 32-bit word selection and flush.
module ysyx_22050612_ifetch_responder
   import ysyx_22050612_ifetch_responder_pkg::*;
#(
   parameter int          LATENCY = 1,
   parameter logic [63:0] BASE    = PMEM_BASE,
   parameter logic [63:0] SIZE    = PMEM_SIZE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_inst,
   output logic        resp_err,
   output logic        mem_ren,
   output logic [63:0] mem_raddr,
   input  logic [63:0] mem_rdata
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] addr_q, addr_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;

   logic        req_err;
   logic        accept;
   logic        fire;

   ysyx_22050612_fetch_range_chk #(
      .BASE (BASE),
      .SIZE (SIZE)
   ) u_chk (
      .addr (req_addr),
      .err  (req_err)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      err_d   = err_q;

      req_ready = !flush &&
                  (state_q == IDLE ||
                   (state_q == RESP && resp_ready));
      accept    = req_valid && req_ready;
      fire      = (state_q == BUSY) && (cnt_q == 4'd0);

      mem_ren    = fire && !err_q;
      mem_raddr  = addr_q & ~64'h7;
      resp_valid = (state_q == RESP);
      resp_inst  = resp_valid ? inst_q : ERR_INST;
      resp_err   = resp_valid && err_q;

      unique case (state_q)
         IDLE: ;
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               inst_d  = err_q ? ERR_INST
                               : sel_half(mem_rdata, addr_q[2]);
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // a same-cycle accept in RESP overrides the drop to IDLE
      if (accept) begin
         addr_d  = req_addr;
         err_d   = req_err;
         cnt_d   = CNT_INIT;
         state_d = BUSY;
      end

      if (flush) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 64'd0;
         inst_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22050612_ifetch_responder.sv
// Directed bench: cycle vector table on a LATENCY=1 instance plus
// hand sequences on LATENCY=3 and LATENCY=4 instances.
module tb_ysyx_22050612_ifetch_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic [63:0] req_addr = 64'd0;
   logic        resp_ready = 1'b0;

   logic        rr1, vv1, err1, ren1;
   logic [31:0] inst1;
   logic [63:0] ra1, rd1;
   logic        rr3, vv3, err3, ren3;
   logic [31:0] inst3;
   logic [63:0] ra3, rd3;
   logic        rr4, vv4, err4, ren4;
   logic [31:0] inst4;
   logic [63:0] ra4, rd4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic [63:0] mem(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'hAAAA_BBBB_0000_0297;
      return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0] + 32'h1357};
   endfunction

   assign rd1 = mem(ra1);
   assign rd3 = mem(ra3);
   assign rd4 = mem(ra4);

   ysyx_22050612_ifetch_responder #(.LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(rr1), .req_addr(req_addr),
      .resp_valid(vv1), .resp_ready(resp_ready),
      .resp_inst(inst1), .resp_err(err1),
      .mem_ren(ren1), .mem_raddr(ra1), .mem_rdata(rd1)
   );

   ysyx_22050612_ifetch_responder #(.LATENCY(3)) u3 (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(rr3), .req_addr(req_addr),
      .resp_valid(vv3), .resp_ready(resp_ready),
      .resp_inst(inst3), .resp_err(err3),
      .mem_ren(ren3), .mem_raddr(ra3), .mem_rdata(rd3)
   );

   ysyx_22050612_ifetch_responder #(.LATENCY(4)) u4 (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(rr4), .req_addr(req_addr),
      .resp_valid(vv4), .resp_ready(resp_ready),
      .resp_inst(inst4), .resp_err(err4),
      .mem_ren(ren4), .mem_raddr(ra4), .mem_rdata(rd4)
   );

   typedef struct {
      logic        rst;
      logic        flush;
      logic        rv;
      logic [63:0] addr;
      logic        rdy;
      logic        e_rr;
      logic        e_vv;
      logic [31:0] e_inst;
      logic        e_err;
      logic        e_ren;
      logic [63:0] e_raddr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic fl, input logic rv, input logic [63:0] a,
      input logic rdy, input logic rr, input logic vv,
      input logic [31:0] inst, input logic er,
      input logic ren, input logic [63:0] ra
   );
      vec_t v;
      v.rst = 1'b0; v.flush = fl; v.rv = rv; v.addr = a;
      v.rdy = rdy; v.e_rr = rr; v.e_vv = vv; v.e_inst = inst;
      v.e_err = er; v.e_ren = ren; v.e_raddr = ra;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic ok,
                        input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // measure accept-to-resp_valid edges and mem_ren pulses on u3
   task automatic measure3(input logic [63:0] a, input int lat,
                           input int nren, input logic [31:0] inst,
                           input logic er);
      int n = 0;
      int rc = 0;
      bit raddr_ok = 1'b1;
      req_valid = 1'b1; req_addr = a; resp_ready = 1'b0;
      #1;
      check("m3_accept_rdy", rr3 === 1'b1, {63'd0, rr3}, 64'd1);
      tick();
      req_valid = 1'b0;
      #1;
      while (!vv3 && n < 20) begin
         if (ren3) begin
            rc++;
            if (ra3 !== (a & ~64'h7)) raddr_ok = 1'b0;
         end
         tick();
         n++;
      end
      check("m3_latency", n == lat, 64'(n), 64'(lat));
      check("m3_ren_cnt", rc == nren, 64'(rc), 64'(nren));
      check("m3_raddr", raddr_ok, 64'(raddr_ok), 64'd1);
      check("m3_inst", inst3 === inst, {32'd0, inst3}, {32'd0, inst});
      check("m3_err", err3 === er, {63'd0, err3}, {63'd0, er});
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      #1;
      check("m3_idle", vv3 === 1'b0, {63'd0, vv3}, 64'd0);
   endtask

   initial begin
      logic [63:0] m8, mh;
      bit ok;
      m8 = mem(64'h8000_0008);
      mh = mem(64'h87FF_FFF8);

      vecs.push_back(mk(0,0,64'd0,0, 1,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,1,64'h8000_0000,0, 1,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 0,0,32'h0,0, 1,64'h8000_0000));
      vecs.push_back(mk(0,1,64'h8000_0004,1, 1,1,32'h0000_0297,0,
                        0,64'd0));
      vecs.push_back(mk(0,1,64'h8000_0008,1, 0,0,32'h0,0,
                        1,64'h8000_0000));
      vecs.push_back(mk(0,1,64'h8000_0008,1, 1,1,32'hAAAA_BBBB,0,
                        0,64'd0));
      vecs.push_back(mk(0,0,64'd0,1, 0,0,32'h0,0, 1,64'h8000_0008));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0,1,64'h8000_0010,0, 0,1,m8[31:0],0,
                           0,64'd0));
      vecs.push_back(mk(0,0,64'd0,1, 1,1,m8[31:0],0, 0,64'd0));
      vecs.push_back(mk(0,1,64'h8000_0002,0, 1,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 0,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,1,64'h7FFF_FFFC,1, 1,1,32'h0,1, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 0,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,1, 1,1,32'h0,1, 0,64'd0));
      vecs.push_back(mk(0,1,64'hFFFF_FFFF_FFFF_FFFC,0, 1,0,32'h0,0,
                        0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 0,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 0,1,32'h0,1, 0,64'd0));
      vecs.push_back(mk(1,1,64'h8000_0000,1, 0,1,32'h0,1, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 1,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,1,64'h87FF_FFFC,0, 1,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 0,0,32'h0,0, 1,64'h87FF_FFF8));
      vecs.push_back(mk(0,1,64'h8800_0000,1, 1,1,mh[63:32],0,
                        0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 0,0,32'h0,0, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,1, 1,1,32'h0,1, 0,64'd0));
      vecs.push_back(mk(0,0,64'd0,0, 1,0,32'h0,0, 0,64'd0));

      do_reset();
      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         flush = vecs[i].flush;
         req_valid = vecs[i].rv;
         req_addr = vecs[i].addr;
         resp_ready = vecs[i].rdy;
         #1;
         ok = (rr1 === vecs[i].e_rr) && (vv1 === vecs[i].e_vv) &&
              (inst1 === vecs[i].e_inst) && (err1 === vecs[i].e_err) &&
              (ren1 === vecs[i].e_ren) &&
              (!vecs[i].e_ren || ra1 === vecs[i].e_raddr);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL vec%0d: got rr=%b vv=%b inst=%h err=%b ren=%b ra=%h want rr=%b vv=%b inst=%h err=%b ren=%b ra=%h",
                     i, rr1, vv1, inst1, err1, ren1, ra1,
                     vecs[i].e_rr, vecs[i].e_vv, vecs[i].e_inst,
                     vecs[i].e_err, vecs[i].e_ren, vecs[i].e_raddr);
         end
         tick();
      end

      do_reset();
      measure3(64'h8000_0004, 3, 1, 32'hAAAA_BBBB, 1'b0);
      measure3(64'h8000_0002, 3, 0, 32'h0, 1'b1);
      measure3(64'h7FFF_FFFC, 3, 0, 32'h0, 1'b1);

      // flush on u4 while BUSY with cnt=2
      do_reset();
      req_valid = 1'b1; req_addr = 64'h8000_0000;
      tick();
      req_valid = 1'b0;
      tick();
      flush = 1'b1; req_valid = 1'b1; resp_ready = 1'b1;
      #1;
      check("flush_rdy", rr4 === 1'b0, {63'd0, rr4}, 64'd0);
      tick();
      flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      #1;
      check("flush_idle", rr4 === 1'b1, {63'd0, rr4}, 64'd1);
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (vv4 !== 1'b0 || ren4 !== 1'b0) ok = 1'b0;
         tick();
      end
      check("flush_no_resp", ok, 64'(ok), 64'd1);

      // rst in the middle of BUSY on u4
      req_valid = 1'b1; req_addr = 64'h8000_0004;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1; flush = 1'b1; resp_ready = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0; resp_ready = 1'b0;
      #1;
      ok = (rr4 === 1'b1) && (vv4 === 1'b0) && (inst4 === 32'h0) &&
           (err4 === 1'b0) && (ren4 === 1'b0);
      check("rst_mid_busy", ok, {rr4, vv4, err4, ren4}, 64'h8);
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (vv4 !== 1'b0) ok = 1'b0;
         tick();
      end
      check("rst_no_resp", ok, 64'(ok), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
